// File: rtl/dual_port_lutram.sv
// Byte-maskable dual-port LUT RAM: one write port, one registered read port,
// with a sweep controller that zeroes the whole array after reset or on request.
module dual_port_lutram #(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET                   = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    parameter int BYTE_EN_WIDTH             = SINGLE_ENTRY_SIZE_IN_BITS / 8,
    parameter int WRITE_FIRST_BYPASS        = 1
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    input  logic                                 clear_in,
    input  logic                                 write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     write_set_addr_in,
    input  logic [BYTE_EN_WIDTH-1:0]             write_byte_en_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_in,
    input  logic                                 read_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     read_set_addr_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_out,
    output logic                                 read_valid_out,
    output logic                                 init_busy_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET =
        SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1);

    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem [NUM_SET];

    state_t                               state;
    state_t                               state_nx;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     ptr;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     ptr_nx;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] merged;
    logic                                 idle;
    logic                                 bypass_hit;

    assign idle          = (state == IDLE);
    assign init_busy_out = (state == CLEAR);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        unique case (state)
            IDLE: begin
                if (clear_in) begin
                    state_nx = CLEAR;
                    ptr_nx   = '0;
                end
            end
            CLEAR: begin
                ptr_nx = ptr + 1'b1;
                if (ptr == LAST_SET) begin
                    state_nx = IDLE;
                    ptr_nx   = '0;
                end
            end
            default: begin
                state_nx = CLEAR;
                ptr_nx   = '0;
            end
        endcase
    end

    // Post-write view of the target entry, used for write-first bypass
    always_comb begin
        merged = mem[write_set_addr_in];
        for (int i = 0; i < BYTE_EN_WIDTH; i++) begin
            if (write_byte_en_in[i]) begin
                merged[8*i +: 8] = write_entry_in[8*i +: 8];
            end
        end
    end

    assign bypass_hit = (WRITE_FIRST_BYPASS != 0) && write_en_in
                        && (write_set_addr_in == read_set_addr_in);

    // Array has no reset so it maps onto distributed RAM; the sweep zeroes it
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            if (state == CLEAR) begin
                mem[ptr] <= '0;
            end else if (write_en_in) begin
                for (int i = 0; i < BYTE_EN_WIDTH; i++) begin
                    if (write_byte_en_in[i]) begin
                        mem[write_set_addr_in][8*i +: 8] <= write_entry_in[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            read_entry_out <= '0;
            read_valid_out <= 1'b0;
        end else begin
            read_valid_out <= idle && read_en_in;
            if (idle && read_en_in) begin
                read_entry_out <= bypass_hit ? merged : mem[read_set_addr_in];
            end
        end
    end

endmodule

// File: tb/tb_dual_port_lutram.sv
// Scoreboard bench for dual_port_lutram: reads queue expected data,
// the negedge monitor pops and compares on every valid pulse.
module tb_dual_port_lutram;

    localparam int W  = 64;
    localparam int N  = 64;
    localparam int AW = 6;
    localparam int BE = 8;

    typedef struct {
        logic [W-1:0] d;
        int           c;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          write_en = 1'b0;
    logic [AW-1:0] wa = '0;
    logic [BE-1:0] be = '0;
    logic [W-1:0]  wd = '0;
    logic          read_en = 1'b0;
    logic [AW-1:0] ra = '0;
    logic [W-1:0]  rd;
    logic          valid;
    logic          busy;
    logic [W-1:0]  rd_old;
    logic          valid_old;
    logic          busy_old;

    logic [W-1:0]  model [N];
    exp_t          q [$];
    exp_t          mon_e;
    logic [W-1:0]  last_rd = '0;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            n_valid = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dual_port_lutram #(.WRITE_FIRST_BYPASS(1)) dut (
        .clk_in            (clk),
        .reset_in          (reset),
        .clear_in          (clear),
        .write_en_in       (write_en),
        .write_set_addr_in (wa),
        .write_byte_en_in  (be),
        .write_entry_in    (wd),
        .read_en_in        (read_en),
        .read_set_addr_in  (ra),
        .read_entry_out    (rd),
        .read_valid_out    (valid),
        .init_busy_out     (busy)
    );

    dual_port_lutram #(.WRITE_FIRST_BYPASS(0)) dut_old (
        .clk_in            (clk),
        .reset_in          (reset),
        .clear_in          (clear),
        .write_en_in       (write_en),
        .write_set_addr_in (wa),
        .write_byte_en_in  (be),
        .write_entry_in    (wd),
        .read_en_in        (read_en),
        .read_set_addr_in  (ra),
        .read_entry_out    (rd_old),
        .read_valid_out    (valid_old),
        .init_busy_out     (busy_old)
    );

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] merge(input logic [W-1:0] old,
                                           input logic [W-1:0] d,
                                           input logic [BE-1:0] m);
        logic [W-1:0] r;
        r = old;
        for (int i = 0; i < BE; i++) begin
            if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            n_valid++;
            if (q.size() == 0) begin
                check("spurious_valid", 64'd1, 64'd0);
            end else begin
                mon_e = q.pop_front();
                check("rd_data", rd, mon_e.d);
                check("rd_latency", 64'(cyc), 64'(mon_e.c));
            end
        end
    end

    // Called just after a negedge; returns at the following negedge
    task automatic step_io(input logic we, input logic [AW-1:0] a_w,
                           input logic [BE-1:0] m, input logic [W-1:0] d,
                           input logic re, input logic [AW-1:0] a_r);
        exp_t e;
        write_en = we;
        wa       = a_w;
        be       = m;
        wd       = d;
        read_en  = re;
        ra       = a_r;
        if (re) begin
            e.d = (we && a_w == a_r) ? merge(model[a_r], d, m) : model[a_r];
            e.c = cyc + 1;
            q.push_back(e);
            last_rd = e.d;
        end
        if (we) model[a_w] = merge(model[a_w], d, m);
        @(negedge clk);
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic zero_model();
        foreach (model[i]) model[i] = '0;
    endtask

    initial begin
        int n;
        int v0;
        zero_model();
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd1);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_rd", rd, 64'd0);

        reset = 1'b0;
        count_busy(n);
        check("init_busy_cycles", 64'(n), 64'd64);
        step_io(0, 0, 0, 0, 1, 0);
        step_io(0, 0, 0, 0, 1, 31);
        step_io(0, 0, 0, 0, 1, 63);
        step_io(0, 0, 0, 0, 0, 0);

        step_io(1, 5, 8'hFF, 64'h1122334455667788, 0, 0);
        step_io(1, 5, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 0, 0);
        step_io(0, 0, 0, 0, 1, 5);
        step_io(0, 0, 0, 0, 0, 0);
        step_io(1, 9, 8'h00, 64'hFFFFFFFFFFFFFFFF, 0, 0);
        step_io(0, 0, 0, 0, 1, 9);
        step_io(0, 0, 0, 0, 0, 0);

        step_io(1, 7, 8'h03, 64'h000000000000DEAD, 1, 7);
        check("no_bypass_old", rd_old, 64'd0);
        check("no_bypass_valid", 64'(valid_old), 64'd1);
        step_io(1, 3, 8'hFF, 64'h0123456789ABCDEF, 1, 9);
        step_io(0, 0, 0, 0, 1, 3);

        for (int i = 0; i < N; i++) step_io(1, AW'(i), 8'hFF, 64'(i), 0, 0);
        v0 = n_valid;
        for (int i = 0; i < N; i++) step_io(0, 0, 0, 0, 1, AW'(i));
        step_io(0, 0, 0, 0, 0, 0);
        check("b2b_valid_count", 64'(n_valid - v0), 64'd64);

        for (int i = 0; i < N; i++)
            step_io(1, AW'(i), 8'hFF, {32'hC0DE0000, 32'(i)}, 0, 0);
        step_io(0, 0, 0, 0, 1, 12);
        step_io(0, 0, 0, 0, 0, 0);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        v0 = n_valid;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            check("sweep_hold_rd", rd, last_rd);
            n++;
            write_en = 1'b1;
            wa       = AW'($urandom_range(0, N - 1));
            be       = 8'hFF;
            wd       = {$urandom, $urandom} | 64'h1;
            read_en  = 1'b1;
            ra       = AW'($urandom_range(0, N - 1));
            clear    = 1'b1;
            @(negedge clk);
        end
        write_en = 1'b0;
        read_en  = 1'b0;
        clear    = 1'b0;
        check("clear_busy_cycles", 64'(n), 64'd64);
        check("sweep_no_valid", 64'(n_valid - v0), 64'd0);
        zero_model();
        for (int i = 0; i < N; i++) step_io(0, 0, 0, 0, 1, AW'(i));
        step_io(0, 0, 0, 0, 0, 0);

        step_io(1, 5, 8'hFF, 64'h5555AAAA5555AAAA, 0, 0);
        step_io(1, 40, 8'hF0, 64'h4040404040404040, 0, 0);
        step_io(0, 0, 0, 0, 1, 5);
        step_io(0, 0, 0, 0, 0, 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (20) @(negedge clk);
        check("busy_mid_sweep", 64'(busy), 64'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_mid_rd", rd, 64'd0);
        check("reset_mid_valid", 64'(valid), 64'd0);
        reset = 1'b0;
        count_busy(n);
        check("restart_busy_cycles", 64'(n), 64'd64);
        zero_model();
        step_io(0, 0, 0, 0, 1, 5);
        step_io(0, 0, 0, 0, 1, 40);
        step_io(0, 0, 0, 0, 1, 63);
        step_io(0, 0, 0, 0, 0, 0);
        step_io(0, 0, 0, 0, 0, 0);
        check("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
